// File: rtl/freg_bus_if.sv
// Request/response handshake and file-register array bus for freg_bus_master.
// master: the bus master's view; slave: requester plus array side.
interface freg_bus_if #(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned L2_NUM_FREG = 5
);
  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_op;
  logic [L2_NUM_FREG-1:0] req_addr;
  logic [DWIDTH-1:0]      req_wdata;
  logic [2:0]             req_bit;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DWIDTH-1:0]      rsp_data;
  logic                   rsp_zero;
  logic                   rsp_err;
  logic [L2_NUM_FREG-1:0] rf_addr;
  logic                   rf_rden;
  logic                   rf_wren;
  logic [DWIDTH-1:0]      rf_wdata;
  logic [DWIDTH-1:0]      rf_rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, req_bit, rsp_ready, rf_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
           rf_addr, rf_rden, rf_wren, rf_wdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, req_bit, rsp_ready, rf_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
           rf_addr, rf_rden, rf_wren, rf_wdata
  );
endinterface

// File: rtl/freg_bus_master.sv
// File-register bus master: plain reads/writes and read-modify-write ops, one op in flight.
// Optional write read-back check enabled by defining FREG_MASTER_RDBACK_EN.
module freg_bus_master #(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned L2_NUM_FREG = 5
) (
  input  logic         clk,
  input  logic         rst,
  freg_bus_if.master   io_bus
);

  localparam int unsigned HALF = DWIDTH / 2;

  typedef enum logic [2:0] {
    OP_RD   = 3'b000,
    OP_WR   = 3'b001,
    OP_BSET = 3'b010,
    OP_BCLR = 3'b011,
    OP_INC  = 3'b100,
    OP_DEC  = 3'b101,
    OP_SWAP = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_WRITE,
    S_VERIFY,
    S_CHECK,
    S_RESP
  } state_e;

  state_e                 r_state,      w_state_nx;
  op_e                    r_op,         w_op_nx;
  logic [2:0]             r_bit,        w_bit_nx;
  logic [DWIDTH-1:0]      r_result,     w_result_nx;
  logic                   r_req_ready,  w_req_ready_nx;
  logic                   r_rsp_valid,  w_rsp_valid_nx;
  logic [DWIDTH-1:0]      r_rsp_data,   w_rsp_data_nx;
  logic                   r_rsp_zero,   w_rsp_zero_nx;
  logic                   r_rsp_err,    w_rsp_err_nx;
  logic [L2_NUM_FREG-1:0] r_rf_addr,    w_rf_addr_nx;
  logic                   r_rf_rden,    w_rf_rden_nx;
  logic                   r_rf_wren,    w_rf_wren_nx;
  logic [DWIDTH-1:0]      r_rf_wdata,   w_rf_wdata_nx;

  op_e                    w_req_op;
  logic                   w_req_wr_only;
  logic                   w_op_wr_only;
  logic [DWIDTH-1:0]      w_mask;
  logic [DWIDTH-1:0]      w_rmw;

  assign w_req_op      = op_e'(io_bus.req_op);
  assign w_req_wr_only = (w_req_op == OP_WR) || (w_req_op == OP_CLR);
  assign w_op_wr_only  = (r_op == OP_WR) || (r_op == OP_CLR);
  assign w_mask        = DWIDTH'(1) << r_bit;

  // Modify step applied to the value captured from the array
  always_comb begin
    w_rmw = io_bus.rf_rdata;
    case (r_op)
      OP_BSET: w_rmw = io_bus.rf_rdata | w_mask;
      OP_BCLR: w_rmw = io_bus.rf_rdata & ~w_mask;
      OP_INC:  w_rmw = io_bus.rf_rdata + DWIDTH'(1);
      OP_DEC:  w_rmw = io_bus.rf_rdata - DWIDTH'(1);
      OP_SWAP: w_rmw = {io_bus.rf_rdata[HALF-1:0], io_bus.rf_rdata[DWIDTH-1:HALF]};
      default: w_rmw = io_bus.rf_rdata;
    endcase
  end

  // Next state and next value of every registered output
  always_comb begin
    w_state_nx     = r_state;
    w_op_nx        = r_op;
    w_bit_nx       = r_bit;
    w_result_nx    = r_result;
    w_rsp_valid_nx = r_rsp_valid;
    w_rsp_data_nx  = r_rsp_data;
    w_rsp_zero_nx  = r_rsp_zero;
    w_rsp_err_nx   = r_rsp_err;
    w_rf_addr_nx   = r_rf_addr;
    w_rf_rden_nx   = 1'b0;
    w_rf_wren_nx   = 1'b0;
    w_rf_wdata_nx  = r_rf_wdata;

    case (r_state)
      S_IDLE: begin
        if (io_bus.req_valid && r_req_ready) begin
          w_op_nx      = w_req_op;
          w_bit_nx     = io_bus.req_bit;
          w_rf_addr_nx = io_bus.req_addr;
          w_result_nx  = (w_req_op == OP_CLR) ? '0 : io_bus.req_wdata;
          w_rsp_err_nx = 1'b0;
          w_state_nx   = S_ISSUE;
          if (w_req_wr_only) begin
            w_rf_wren_nx  = 1'b1;
            w_rf_wdata_nx = w_result_nx;
          end else begin
            w_rf_rden_nx  = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        if (w_op_wr_only) begin
`ifdef FREG_MASTER_RDBACK_EN
          w_rf_rden_nx   = 1'b1;
          w_state_nx     = S_VERIFY;
`else
          w_rsp_valid_nx = 1'b1;
          w_rsp_data_nx  = r_result;
          w_rsp_zero_nx  = (r_result == '0);
          w_state_nx     = S_RESP;
`endif
        end else begin
          w_state_nx = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (r_op == OP_RD) begin
          w_rsp_valid_nx = 1'b1;
          w_rsp_data_nx  = io_bus.rf_rdata;
          w_rsp_zero_nx  = (io_bus.rf_rdata == '0);
          w_state_nx     = S_RESP;
        end else begin
          w_result_nx    = w_rmw;
          w_rf_wren_nx   = 1'b1;
          w_rf_wdata_nx  = w_rmw;
          w_state_nx     = S_WRITE;
        end
      end

      S_WRITE: begin
`ifdef FREG_MASTER_RDBACK_EN
        w_rf_rden_nx   = 1'b1;
        w_state_nx     = S_VERIFY;
`else
        w_rsp_valid_nx = 1'b1;
        w_rsp_data_nx  = r_result;
        w_rsp_zero_nx  = (r_result == '0);
        w_state_nx     = S_RESP;
`endif
      end

`ifdef FREG_MASTER_RDBACK_EN
      S_VERIFY: begin
        w_state_nx = S_CHECK;
      end

      S_CHECK: begin
        w_rsp_err_nx   = (io_bus.rf_rdata != r_result);
        w_rsp_valid_nx = 1'b1;
        w_rsp_data_nx  = r_result;
        w_rsp_zero_nx  = (r_result == '0);
        w_state_nx     = S_RESP;
      end
`endif

      S_RESP: begin
        if (io_bus.rsp_ready) begin
          w_rsp_valid_nx = 1'b0;
          w_state_nx     = S_IDLE;
        end
      end

      default: w_state_nx = S_IDLE;
    endcase

    w_req_ready_nx = (w_state_nx == S_IDLE);
  end

  // Synchronous reset drops any pending access before it reaches the array
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_RD;
      r_bit       <= '0;
      r_result    <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_rden   <= 1'b0;
      r_rf_wren   <= 1'b0;
      r_rf_wdata  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_op        <= w_op_nx;
      r_bit       <= w_bit_nx;
      r_result    <= w_result_nx;
      r_req_ready <= w_req_ready_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_data  <= w_rsp_data_nx;
      r_rsp_zero  <= w_rsp_zero_nx;
      r_rsp_err   <= w_rsp_err_nx;
      r_rf_addr   <= w_rf_addr_nx;
      r_rf_rden   <= w_rf_rden_nx;
      r_rf_wren   <= w_rf_wren_nx;
      r_rf_wdata  <= w_rf_wdata_nx;
    end
  end

  assign io_bus.req_ready = r_req_ready;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.rsp_zero  = r_rsp_zero;
  assign io_bus.rsp_err   = r_rsp_err;
  assign io_bus.rf_addr   = r_rf_addr;
  assign io_bus.rf_rden   = r_rf_rden;
  assign io_bus.rf_wren   = r_rf_wren;
  assign io_bus.rf_wdata  = r_rf_wdata;

endmodule

// File: tb/tb_freg_bus_master.sv
// Directed bench for freg_bus_master with a behavioural file-register array (FSR at 4, INDF at 0).
// Build with FREG_MASTER_RDBACK_EN defined to exercise the read-back variant.
module tb_freg_bus_master;

  localparam logic [2:0] OP_RD = 3'd0, OP_WR = 3'd1, OP_BSET = 3'd2, OP_BCLR = 3'd3,
                         OP_INC = 3'd4, OP_DEC = 3'd5, OP_SWAP = 3'd6, OP_CLR = 3'd7;
`ifdef FREG_MASTER_RDBACK_EN
  localparam int LAT_WR = 4, LAT_RMW = 6, RD_PER_WR = 1;
`else
  localparam int LAT_WR = 2, LAT_RMW = 4, RD_PER_WR = 0;
`endif
  localparam int LAT_RD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  freg_bus_if #(.DWIDTH(8), .L2_NUM_FREG(5)) bus ();

  freg_bus_master #(.DWIDTH(8), .L2_NUM_FREG(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Array model: INDF (addr 0) redirects through FSR (addr 4); read data registered
  logic [7:0] mem [32];
  logic [7:0] rdata_q = 8'h00;
  logic       corrupt = 1'b0;
  int         n_wren = 0, n_rden = 0;
  logic       overlap = 1'b0;
  logic [4:0] last_addr = 5'd0;

  function automatic logic [4:0] eff_addr(input logic [4:0] a);
    logic [7:0] fsr;
    fsr = mem[4];
    return (a == 5'd0) ? fsr[4:0] : a;
  endfunction

  always @(posedge clk) begin
    if (bus.rf_wren) begin
      mem[eff_addr(bus.rf_addr)] <= bus.rf_wdata;
      n_wren    <= n_wren + 1;
      last_addr <= bus.rf_addr;
    end
    if (bus.rf_rden) begin
      rdata_q   <= mem[eff_addr(bus.rf_addr)] ^ (corrupt ? 8'h01 : 8'h00);
      n_rden    <= n_rden + 1;
      last_addr <= bus.rf_addr;
    end
    if (bus.rf_rden && bus.rf_wren) overlap <= 1'b1;
  end
  assign bus.rf_rdata = rdata_q;

  // Drives one request and returns the response; lat is edges from accept (inclusive), 0 on timeout
  task automatic do_op(input logic [2:0] op, input logic [4:0] addr, input logic [7:0] wd,
                       input logic [2:0] b, output logic [7:0] d, output logic z,
                       output logic e, output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
    bus.req_wdata = wd;   bus.req_bit = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_wdata = 8'hEE; bus.req_addr = 5'h1F; bus.req_bit = 3'd5;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = i; break; end
      @(posedge clk);
    end
    d = bus.rsp_data; z = bus.rsp_zero; e = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 ||
        bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: rdy=%b vld=%b data=%h zero=%b err=%b, required 1 0 00 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err);
    end
    n_tests++;
    if (bus.rf_rden !== 1'b0 || bus.rf_wren !== 1'b0 || bus.rf_addr !== 5'd0 ||
        bus.rf_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rf: rden=%b wren=%b addr=%h wdata=%h, required 0 0 00 00",
               bus.rf_rden, bus.rf_wren, bus.rf_addr, bus.rf_wdata);
    end
  endtask

  task automatic test_wr_rd();
    logic [7:0] d; logic z, e; int lat, w0, r0;
    w0 = n_wren; r0 = n_rden;
    do_op(OP_WR, 5'h10, 8'h5A, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h5A || z !== 1'b0 || e !== 1'b0 || lat != LAT_WR || last_addr !== 5'h10) begin
      n_fail++;
      $display("FAIL wr_10: data=%h zero=%b err=%b lat=%0d addr=%h, required 5a 0 0 %0d 10",
               d, z, e, lat, last_addr, LAT_WR);
    end
    do_op(OP_RD, 5'h10, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h5A || z !== 1'b0 || lat != LAT_RD) begin
      n_fail++;
      $display("FAIL rd_10: data=%h zero=%b lat=%0d, required 5a 0 %0d", d, z, lat, LAT_RD);
    end
    n_tests++;
    if (n_wren - w0 != 1 || n_rden - r0 != 1 + RD_PER_WR) begin
      n_fail++;
      $display("FAIL strobe_count: wren=%0d rden=%0d, required 1 %0d",
               n_wren - w0, n_rden - r0, 1 + RD_PER_WR);
    end
  endtask

  task automatic test_inc_dec();
    logic [7:0] d; logic z, e; int lat;
    do_op(OP_WR, 5'h11, 8'hFF, 3'd0, d, z, e, lat);
    do_op(OP_INC, 5'h11, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h00 || z !== 1'b1 || lat != LAT_RMW) begin
      n_fail++;
      $display("FAIL inc_wrap: data=%h zero=%b lat=%0d, required 00 1 %0d", d, z, lat, LAT_RMW);
    end
    do_op(OP_RD, 5'h11, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h00 || z !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_11: data=%h zero=%b, required 00 1", d, z);
    end
    do_op(OP_DEC, 5'h11, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'hFF || z !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_wrap: data=%h zero=%b, required ff 0", d, z);
    end
  endtask

  task automatic test_bit_swap();
    logic [7:0] d; logic z, e; int lat;
    do_op(OP_WR, 5'h12, 8'h01, 3'd0, d, z, e, lat);
    do_op(OP_BSET, 5'h12, 8'h00, 3'd7, d, z, e, lat);
    n_tests++;
    if (d !== 8'h81) begin n_fail++; $display("FAIL bset7: data=%h, required 81", d); end
    do_op(OP_BCLR, 5'h12, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h80) begin n_fail++; $display("FAIL bclr0: data=%h, required 80", d); end
    do_op(OP_SWAP, 5'h12, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h08) begin n_fail++; $display("FAIL swap: data=%h, required 08", d); end
    do_op(OP_RD, 5'h12, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h08) begin n_fail++; $display("FAIL rd_12: data=%h, required 08", d); end
  endtask

  task automatic test_indirect_clr();
    logic [7:0] d; logic z, e; int lat;
    do_op(OP_WR, 5'h04, 8'h13, 3'd0, d, z, e, lat);
    do_op(OP_WR, 5'h00, 8'h33, 3'd0, d, z, e, lat);
    do_op(OP_RD, 5'h13, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h33) begin n_fail++; $display("FAIL indirect: data=%h, required 33", d); end
    do_op(OP_WR, 5'h15, 8'h77, 3'd0, d, z, e, lat);
    do_op(OP_CLR, 5'h15, 8'hAA, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h00 || z !== 1'b1 || lat != LAT_WR) begin
      n_fail++;
      $display("FAIL clr: data=%h zero=%b lat=%0d, required 00 1 %0d", d, z, lat, LAT_WR);
    end
    do_op(OP_RD, 5'h15, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL rd_15: data=%h, required 00", d); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d; logic z, e; int lat, w0;
    bool_seen: begin end
    w0 = n_wren;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_RD; bus.req_addr = 5'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = i; break; end
      @(posedge clk);
    end
    n_tests++;
    if (lat != LAT_RD) begin n_fail++; $display("FAIL bp_lat: lat=%0d, required %0d", lat, LAT_RD); end
    // Competing request while the response is stalled must be ignored
    bus.req_valid = 1'b1; bus.req_op = OP_WR; bus.req_addr = 5'h10; bus.req_wdata = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: vld=%b data=%h rdy=%b, required 1 5a 0",
                 c, bus.rsp_valid, bus.rsp_data, bus.req_ready);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || n_wren != w0) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b writes=%0d, required 0 1 0",
               bus.rsp_valid, bus.req_ready, n_wren - w0);
    end
    do_op(OP_RD, 5'h10, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL bp_rd: data=%h, required 5a", d); end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] d; logic z, e; int lat, w0;
    do_op(OP_WR, 5'h16, 8'h40, 3'd0, d, z, e, lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_INC; bus.req_addr = 5'h16;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    w0 = n_wren;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 ||
        bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rf_rden !== 1'b0 ||
        bus.rf_wren !== 1'b0 || bus.rf_addr !== 5'd0 || bus.rf_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_outs: rdy=%b vld=%b data=%h zero=%b err=%b rden=%b wren=%b addr=%h wdata=%h, required reset values",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err,
               bus.rf_rden, bus.rf_wren, bus.rf_addr, bus.rf_wdata);
    end
    repeat (3) @(posedge clk);
    n_tests++;
    if (n_wren != w0) begin
      n_fail++;
      $display("FAIL midrst_nowrite: writes=%0d, required 0", n_wren - w0);
    end
    do_op(OP_RD, 5'h16, 8'h00, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL midrst_rd: data=%h, required 40", d); end
  endtask

`ifdef FREG_MASTER_RDBACK_EN
  task automatic test_readback();
    logic [7:0] d; logic z, e; int lat;
    do_op(OP_WR, 5'h14, 8'hA5, 3'd0, d, z, e, lat);
    n_tests++;
    if (d !== 8'hA5 || e !== 1'b0 || lat != 4) begin
      n_fail++;
      $display("FAIL rdback_ok: data=%h err=%b lat=%0d, required a5 0 4", d, e, lat);
    end
    corrupt = 1'b1;
    do_op(OP_WR, 5'h17, 8'h3C, 3'd0, d, z, e, lat);
    corrupt = 1'b0;
    n_tests++;
    if (d !== 8'h3C || e !== 1'b1) begin
      n_fail++;
      $display("FAIL rdback_err: data=%h err=%b, required 3c 1", d, e);
    end
  endtask
`endif

  task automatic test_strobes();
    n_tests++;
    if (overlap !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_overlap: seen=%b, required 0", overlap);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 5'd0;
    bus.req_wdata = 8'h00; bus.req_bit = 3'd0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_wr_rd();
    test_inc_dec();
    test_bit_swap();
    test_indirect_clr();
    test_backpressure();
    test_reset_mid_op();
`ifdef FREG_MASTER_RDBACK_EN
    test_readback();
`endif
    test_strobes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
